muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32 (the data_size constant), operand and result width, any even value 8..64.
REQ-002 SHALL have parameter CNT_W, default $clog2(DATA_W)+1, iteration counter width.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start_i  input  1  request valid; accepted only while ready_o=1.
REQ-006 SHALL have port funct_i  input  3  M-extension funct3: mul, mulh, mulhsu, mulhu, div, divu, rem, remu.
REQ-007 SHALL have ports op_a_i, op_b_i  input  DATA_W  rs1 and rs2 operands.
REQ-008 SHALL have port flush_i  input  1  abort the in-flight operation (pipeline flush).
REQ-009 SHALL have port ready_o  output  1  unit can accept a request this cycle.
REQ-010 SHALL have port busy_o  output  1  operation in flight; drives the hazard unit stall.
REQ-011 SHALL have port done_o  output  1  one-cycle pulse, result_o valid.
REQ-012 SHALL have port result_o  output  DATA_W  result; held from done_o until the next accepted request.

Function
REQ-013 SHALL implement states IDLE, CALC, FIX, DONE.
REQ-014 SHALL accept a request at cycle T when start_i=1 and ready_o=1, latching funct_i, operands and operand signs.
REQ-015 SHALL assert ready_o in IDLE and DONE only; a start in DONE is accepted back-to-back.
REQ-016 SHALL run multiply as radix-2 shift-add on operand magnitudes, 2*DATA_W-bit product, DATA_W iterations in CALC.
REQ-017 SHALL run divide as radix-2 restoring division on magnitudes, DATA_W iterations in CALC.
REQ-018 SHALL apply sign correction in FIX: mul/mulh negate the product if the signs differ; mulhsu treats only op_a as signed; div negates the quotient if the signs differ; rem takes the sign of the dividend.
REQ-019 SHALL return the low DATA_W product bits for mul, the high DATA_W bits for mulh/mulhsu/mulhu.
REQ-020 SHALL assert done_o in cycle T+DATA_W+2 for normal operations (CALC T+1..T+DATA_W, FIX T+DATA_W+1).
REQ-021 SHALL handle divide by zero via a fast path to DONE: done_o at T+1; div/divu give all ones; rem/remu give the dividend.
REQ-022 SHALL handle signed overflow (most negative / -1) via the fast path: div gives the dividend; rem gives 0; done_o at T+1.
REQ-023 SHALL NOT fast-path multiply by zero; it takes the full latency.
REQ-024 SHALL, on flush_i=1 in CALC or FIX, go to IDLE next cycle with no done_o; result_o is unchanged.
REQ-025 SHALL let flush_i win over start_i in the same cycle: the request is not accepted.
REQ-026 SHALL let flush_i in DONE suppress nothing (done_o already issued) and move to IDLE.
REQ-027 SHALL assert busy_o in CALC and FIX, and in the acceptance cycle combinationally from start_i&ready_o.
REQ-028 SHALL treat an unknown funct_i as mul.

Reset
REQ-029 SHALL, on rst=1 at any cycle including mid-operation, next cycle have state IDLE, result_o=0, done_o=0, busy_o=0, ready_o=1, counter=0.
REQ-030 SHALL let rst override flush_i and start_i.

Structure
REQ-031 SHALL place the muldiv_state enum and an mext_funct7 constant (7'h01) in the shared constants package; the funct3 values SHALL reuse the existing mul_func..remu_func constants.
REQ-032 SHALL contain one sub-module, muldiv_datapath (shift registers, adder/subtractor, counter); FSM and sign logic stay in muldiv_unit.

Verification
REQ-033 SHALL cover: DATA_W=32, mul 7 x 0xFFFFFFFD -> 0xFFFFFFEB, done_o exactly at T+34, single pulse.
REQ-034 SHALL cover: mulhu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; mulh with the same operands -> 0x00000000.
REQ-035 SHALL cover: div 0x80000000 / 0xFFFFFFFF -> 0x80000000 and rem -> 0, done_o at T+1; divu 5/0 -> 0xFFFFFFFF and remu 5/0 -> 5, done_o at T+1.
REQ-036 SHALL cover: divu 100/7 accepted, flush_i at T+10 -> IDLE at T+11, no done_o, result_o unchanged; new divu 100/7 -> 14, remu -> 2.
REQ-037 SHALL cover: DATA_W=16, div 0xFFF9 / 2 -> 0xFFFD and rem -> 0xFFFF, done_o at T+18.
REQ-038 SHALL cover: rst at T+5 of a div -> all outputs at reset values next cycle; start in the DONE cycle accepted back-to-back.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the M-extension multiply/divide unit: funct codes and FSM states.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package muldiv_unit_pkg;

  // funct7 value that selects the M extension in an R-type instruction
  localparam logic [6:0] mext_funct7 = 7'h01;

  // funct3 encodings of the eight M-extension operations
  localparam logic [2:0] mul_func    = 3'b000;
  localparam logic [2:0] mulh_func   = 3'b001;
  localparam logic [2:0] mulhsu_func = 3'b010;
  localparam logic [2:0] mulhu_func  = 3'b011;
  localparam logic [2:0] div_func    = 3'b100;
  localparam logic [2:0] divu_func   = 3'b101;
  localparam logic [2:0] rem_func    = 3'b110;
  localparam logic [2:0] remu_func   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state;

endpackage

// File: rtl/muldiv_unit_datapath.sv
// Radix-2 iteration engine: shift-add multiply or restoring divide on unsigned magnitudes.
// Latency: one iteration per step cycle, DATA_W steps produce the full result in {hi, lo}.
// Backpressure: none; the controlling FSM decides when to load and step.
module muldiv_datapath #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [DATA_W-1:0] a_mag,
  input  logic [DATA_W-1:0] b_mag,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              last
);

  // hi holds the partial product / partial remainder, lo the multiplier / quotient bits
  logic [DATA_W-1:0] divisor;
  logic              div_mode;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W:0]   base;
  logic [DATA_W:0]   operand;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] hi_nxt;
  logic [DATA_W-1:0] lo_nxt;

  // One shared adder: subtract the divisor when dividing, add the multiplicand when multiplying
  always_comb begin
    base    = div_mode ? {hi, lo[DATA_W-1]} : {1'b0, hi};
    operand = '0;
    if (div_mode) begin
      operand = ~{1'b0, divisor};
    end else if (lo[0]) begin
      operand = {1'b0, divisor};
    end
    sum = base + operand + {{DATA_W{1'b0}}, div_mode};
    if (div_mode) begin
      // A set top bit means the trial subtraction went negative: restore and shift in 0
      if (sum[DATA_W]) begin
        hi_nxt = base[DATA_W-1:0];
        lo_nxt = {lo[DATA_W-2:0], 1'b0};
      end else begin
        hi_nxt = sum[DATA_W-1:0];
        lo_nxt = {lo[DATA_W-2:0], 1'b1};
      end
    end else begin
      hi_nxt = sum[DATA_W:1];
      lo_nxt = {sum[0], lo[DATA_W-1:1]};
    end
  end

  // Operand load on acceptance, then one iteration per step with the iteration count
  always_ff @(posedge clk) begin
    if (rst) begin
      hi       <= '0;
      lo       <= '0;
      divisor  <= '0;
      div_mode <= 1'b0;
      cnt      <= '0;
    end else if (load) begin
      hi       <= '0;
      lo       <= a_mag;
      divisor  <= b_mag;
      div_mode <= is_div;
      cnt      <= '0;
    end else if (step) begin
      hi  <= hi_nxt;
      lo  <= lo_nxt;
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last = (cnt == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit with sign handling and fast paths.
// Latency: done_o at T+DATA_W+2 after acceptance; divide-by-zero and signed overflow at T+1.
// Backpressure: ready_o only in IDLE/DONE; start_i outside ready_o, or with flush_i, is dropped.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        funct_i,
  input  logic [DATA_W-1:0] op_a_i,
  input  logic [DATA_W-1:0] op_b_i,
  input  logic              flush_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o
);

  localparam logic [DATA_W-1:0] min_neg = {1'b1, {(DATA_W-1){1'b0}}};

  muldiv_state         state, state_nxt;
  logic [2:0]          funct_q;
  logic                neg_a_q, neg_res_q;
  logic                accept;
  logic                a_signed, b_signed, is_div;
  logic                neg_a, neg_b;
  logic                div_zero, div_ovf, fast;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [DATA_W-1:0]   fast_res, fix_res;
  logic [DATA_W-1:0]   hi, lo;
  logic                last;
  logic [2*DATA_W-1:0] prod_s;

  assign ready_o = (state == IDLE) || (state == DONE);
  assign accept  = start_i && ready_o && !flush_i && !rst;

  // Decode signedness of the incoming request and spot the single-cycle divide cases
  always_comb begin
    a_signed = 1'b1;
    b_signed = 1'b1;
    is_div   = 1'b0;
    case (funct_i)
      mulhsu_func: b_signed = 1'b0;
      mulhu_func: begin
        a_signed = 1'b0;
        b_signed = 1'b0;
      end
      div_func, rem_func: is_div = 1'b1;
      divu_func, remu_func: begin
        is_div   = 1'b1;
        a_signed = 1'b0;
        b_signed = 1'b0;
      end
      default: ;  // mul, mulh and anything unresolved behave as signed multiply
    endcase
    neg_a    = a_signed && op_a_i[DATA_W-1];
    neg_b    = b_signed && op_b_i[DATA_W-1];
    a_mag    = neg_a ? -op_a_i : op_a_i;
    b_mag    = neg_b ? -op_b_i : op_b_i;
    div_zero = is_div && (op_b_i == '0);
    div_ovf  = is_div && a_signed && (op_a_i == min_neg) && (op_b_i == '1);
    fast     = div_zero || div_ovf;
    // funct_i[1] separates rem/remu from div/divu
    if (div_zero) begin
      fast_res = funct_i[1] ? op_a_i : '1;
    end else begin
      fast_res = funct_i[1] ? '0 : op_a_i;
    end
  end

  // Sign correction of the magnitude result, selected by the latched operation
  always_comb begin
    prod_s = neg_res_q ? -{hi, lo} : {hi, lo};
    case (funct_q)
      mulh_func, mulhsu_func, mulhu_func: fix_res = prod_s[2*DATA_W-1:DATA_W];
      div_func, divu_func:                fix_res = neg_res_q ? -lo : lo;
      rem_func, remu_func:                fix_res = neg_a_q ? -hi : hi;
      default:                            fix_res = prod_s[DATA_W-1:0];
    endcase
  end

  // Next-state and status outputs; flush abandons any in-flight work without a done pulse
  always_comb begin
    state_nxt = state;
    busy_o    = accept;
    done_o    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = fast ? DONE : CALC;
      end
      CALC: begin
        busy_o = 1'b1;
        if (flush_i)   state_nxt = IDLE;
        else if (last) state_nxt = FIX;
      end
      FIX: begin
        busy_o    = 1'b1;
        state_nxt = flush_i ? IDLE : DONE;
      end
      DONE: begin
        done_o = 1'b1;
        if (accept) state_nxt = fast ? DONE : CALC;
        else        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and request latch of operation and operand signs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      funct_q   <= mul_func;
      neg_a_q   <= 1'b0;
      neg_res_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        funct_q   <= funct_i;
        neg_a_q   <= neg_a;
        neg_res_q <= neg_a ^ neg_b;
      end
    end
  end

  // Result register: written by the fast path or at the end of FIX, otherwise held
  always_ff @(posedge clk) begin
    if (rst) begin
      result_o <= '0;
    end else if (accept && fast) begin
      result_o <= fast_res;
    end else if ((state == FIX) && !flush_i) begin
      result_o <= fix_res;
    end
  end

  muldiv_datapath #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) u_datapath (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .step  (state == CALC),
    .is_div(is_div),
    .a_mag (a_mag),
    .b_mag (b_mag),
    .hi    (hi),
    .lo    (lo),
    .last  (last)
  );

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at DATA_W=32 and DATA_W=16 against an arithmetic model.
// Latency: checks done_o cycle against the acceptance cycle of every request.
// Backpressure: drives start_i only while ready_o is expected high.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start32, flush32, ready32, busy32, done32;
  logic [2:0]  funct32;
  logic [31:0] a32, b32, res32;
  logic        start16, flush16, ready16, busy16, done16;
  logic [2:0]  funct16;
  logic [15:0] a16, b16, res16;

  int          errors = 0;
  int          checks = 0;
  logic        cur16 = 1'b0;
  logic [63:0] exp_res;
  int          exp_lat;

  logic        done_s, busy_s, ready_s;
  logic [63:0] res_s;

  always #5 clk = ~clk;

  muldiv_unit #(.DATA_W(32)) u32 (
    .clk(clk), .rst(rst), .start_i(start32), .funct_i(funct32), .op_a_i(a32), .op_b_i(b32),
    .flush_i(flush32), .ready_o(ready32), .busy_o(busy32), .done_o(done32), .result_o(res32)
  );

  muldiv_unit #(.DATA_W(16)) u16 (
    .clk(clk), .rst(rst), .start_i(start16), .funct_i(funct16), .op_a_i(a16), .op_b_i(b16),
    .flush_i(flush16), .ready_o(ready16), .busy_o(busy16), .done_o(done16), .result_o(res16)
  );

  assign done_s  = cur16 ? done16 : done32;
  assign busy_s  = cur16 ? busy16 : busy32;
  assign ready_s = cur16 ? ready16 : ready32;
  assign res_s   = cur16 ? {48'd0, res16} : {32'd0, res32};

  // Two's-complement value of the low w bits of x
  function automatic longint sext(input int w, input logic [63:0] x);
    longint unsigned u;
    u = x & ((64'd1 << w) - 64'd1);
    if (((u >> (w - 1)) & 64'd1) != 64'd0) return longint'(u) - (longint'(1) << w);
    return longint'(u);
  endfunction

  // Expected result straight from the M-extension arithmetic definitions
  function automatic logic [63:0] model(input int w, input logic [2:0] f,
                                        input logic [63:0] a, input logic [63:0] b);
    longint unsigned m, ua, ub, up;
    longint          sa, sb, sp, minv;
    m    = (64'd1 << w) - 64'd1;
    ua   = a & m;
    ub   = b & m;
    sa   = sext(w, a);
    sb   = sext(w, b);
    minv = -(longint'(1) << (w - 1));
    case (f)
      3'd1: begin sp = sa * sb;            return (sp >>> w) & m; end
      3'd2: begin sp = sa * longint'(ub);  return (sp >>> w) & m; end
      3'd3: begin up = ua * ub;            return (up >> w) & m; end
      3'd4: begin
        if (ub == 0) return m;
        if (sa == minv && sb == -1) return ua;
        sp = sa / sb; return sp & m;
      end
      3'd5: return (ub == 0) ? m : (ua / ub);
      3'd6: begin
        if (ub == 0) return ua;
        if (sa == minv && sb == -1) return 64'd0;
        sp = sa % sb; return sp & m;
      end
      3'd7: return (ub == 0) ? ua : (ua % ub);
      default: begin sp = sa * sb; return sp & m; end
    endcase
  endfunction

  // Expected acceptance-to-done latency in cycles
  function automatic int model_lat(input int w, input logic [2:0] f,
                                   input logic [63:0] a, input logic [63:0] b);
    longint unsigned ub;
    logic [2:0] fv;
    fv = f;
    ub = b & ((64'd1 << w) - 64'd1);
    if (fv[2] && (ub == 0 || (!fv[0] && sext(w, a) == -(longint'(1) << (w - 1)) && sext(w, b) == -1)))
      return 1;
    return w + 2;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Present a request one cycle (called just after a clock edge); returns in cycle T+1
  task automatic issue(input logic w16, input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
    int w;
    w       = w16 ? 16 : 32;
    cur16   = w16;
    exp_res = model(w, f, a, b);
    exp_lat = model_lat(w, f, a, b);
    if (w16) begin
      start16 = 1'b1; funct16 = f; a16 = a[15:0]; b16 = b[15:0];
    end else begin
      start32 = 1'b1; funct32 = f; a32 = a[31:0]; b32 = b[31:0];
    end
    #1;
    chk("accept_ready", {63'd0, ready_s}, 64'd1);
    chk("accept_busy", {63'd0, busy_s}, 64'd1);
    @(posedge clk); #1;
    start16 = 1'b0;
    start32 = 1'b0;
  endtask

  // Count cycles to done_o and compare latency and result; returns in the DONE cycle
  task automatic wait_done(input string tag);
    int k;
    k = 1;
    if (exp_lat > 1) begin
      chk({tag, "_busy"}, {63'd0, busy_s}, 64'd1);
      chk({tag, "_notready"}, {63'd0, ready_s}, 64'd0);
    end
    while (done_s !== 1'b1 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_lat"}, 64'(k), 64'(exp_lat));
    chk({tag, "_res"}, res_s, exp_res);
  endtask

  task automatic idle_after(input string tag);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {63'd0, done_s}, 64'd0);
    chk({tag, "_idle"}, {63'd0, ready_s}, 64'd1);
  endtask

  task automatic run(input logic w16, input logic [2:0] f, input logic [63:0] a,
                     input logic [63:0] b, input string tag);
    issue(w16, f, a, b);
    wait_done(tag);
    idle_after(tag);
  endtask

  function automatic logic [63:0] rnd_opnd(input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return m;
      2:       return 64'd1 << (w - 1);
      3:       return 64'($urandom_range(0, 20));
      default: return {32'd0, $urandom()} & m;
    endcase
  endfunction

  initial begin
    logic [63:0] prev;
    int          pulses;
    rst = 1'b1;
    start32 = 1'b0; flush32 = 1'b0; funct32 = 3'd0; a32 = '0; b32 = '0;
    start16 = 1'b0; flush16 = 1'b0; funct16 = 3'd0; a16 = '0; b16 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_ready32", {63'd0, ready32}, 64'd1);
    chk("rst_busy32", {63'd0, busy32}, 64'd0);
    chk("rst_done32", {63'd0, done32}, 64'd0);
    chk("rst_res32", {32'd0, res32}, 64'd0);
    chk("rst_ready16", {63'd0, ready16}, 64'd1);
    chk("rst_res16", {48'd0, res16}, 64'd0);

    run(1'b0, mul_func, 64'd7, 64'hFFFF_FFFD, "mul_neg");
    chk("mul_neg_const", {32'd0, res32}, 64'hFFFF_FFEB);
    run(1'b0, mulhu_func, 64'hFFFF_FFFF, 64'hFFFF_FFFF, "mulhu_max");
    chk("mulhu_const", {32'd0, res32}, 64'hFFFF_FFFE);
    run(1'b0, mulh_func, 64'hFFFF_FFFF, 64'hFFFF_FFFF, "mulh_m1");
    chk("mulh_const", {32'd0, res32}, 64'h0);
    run(1'b0, mulhsu_func, 64'hFFFF_FFFF, 64'hFFFF_FFFF, "mulhsu_m1");
    run(1'b0, mul_func, 64'h1234_5678, 64'd0, "mul_zero");

    run(1'b0, div_func, 64'h8000_0000, 64'hFFFF_FFFF, "div_ovf");
    chk("div_ovf_const", {32'd0, res32}, 64'h8000_0000);
    run(1'b0, rem_func, 64'h8000_0000, 64'hFFFF_FFFF, "rem_ovf");
    run(1'b0, divu_func, 64'd5, 64'd0, "divu_zero");
    chk("divu_zero_const", {32'd0, res32}, 64'hFFFF_FFFF);
    run(1'b0, remu_func, 64'd5, 64'd0, "remu_zero");
    chk("remu_zero_const", {32'd0, res32}, 64'd5);

    // Flush asserted together with start: the request must be dropped
    start32 = 1'b1; flush32 = 1'b1; funct32 = divu_func; a32 = 32'd9; b32 = 32'd3;
    #1 chk("flushwin_busy", {63'd0, busy32}, 64'd0);
    @(posedge clk); #1;
    start32 = 1'b0; flush32 = 1'b0;
    chk("flushwin_idle_busy", {63'd0, busy32}, 64'd0);
    chk("flushwin_idle_ready", {63'd0, ready32}, 64'd1);

    // Flush in the middle of a divide
    prev = {32'd0, res32};
    chk("flush_prev", prev, 64'd5);
    issue(1'b0, divu_func, 64'd100, 64'd7);
    repeat (9) @(posedge clk);
    #1 flush32 = 1'b1;
    @(posedge clk); #1;
    flush32 = 1'b0;
    chk("flush_ready", {63'd0, ready32}, 64'd1);
    chk("flush_busy", {63'd0, busy32}, 64'd0);
    chk("flush_done", {63'd0, done32}, 64'd0);
    chk("flush_res", {32'd0, res32}, prev);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done32) pulses++;
    end
    chk("flush_nopulse", 64'(pulses), 64'd0);
    run(1'b0, divu_func, 64'd100, 64'd7, "divu_after_flush");
    chk("divu_const", {32'd0, res32}, 64'd14);
    run(1'b0, remu_func, 64'd100, 64'd7, "remu_after_flush");
    chk("remu_const", {32'd0, res32}, 64'd2);

    run(1'b1, div_func, 64'hFFF9, 64'd2, "div16");
    chk("div16_const", {48'd0, res16}, 64'hFFFD);
    run(1'b1, rem_func, 64'hFFF9, 64'd2, "rem16");
    chk("rem16_const", {48'd0, res16}, 64'hFFFF);

    // Reset in cycle T+5 of a divide
    issue(1'b0, div_func, 64'd1000, 64'd3);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_ready", {63'd0, ready32}, 64'd1);
    chk("midrst_busy", {63'd0, busy32}, 64'd0);
    chk("midrst_done", {63'd0, done32}, 64'd0);
    chk("midrst_res", {32'd0, res32}, 64'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done32) pulses++;
    end
    chk("midrst_nopulse", 64'(pulses), 64'd0);

    // Back-to-back: second request presented in the DONE cycle of the first
    issue(1'b0, mulhu_func, 64'hDEAD_BEEF, 64'h0BAD_F00D);
    wait_done("b2b_first");
    issue(1'b0, rem_func, 64'hFFFF_FF00, 64'd7);
    wait_done("b2b_second");
    idle_after("b2b_second");

    for (int i = 0; i < 30; i++) begin
      run(1'b0, 3'($urandom_range(0, 7)), rnd_opnd(32), rnd_opnd(32), "rand32");
    end
    for (int i = 0; i < 20; i++) begin
      run(1'b1, 3'($urandom_range(0, 7)), rnd_opnd(16), rnd_opnd(16), "rand16");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
